// File: rtl/uart_crc_receiver.sv
`default_nettype none
// ============================================================================
// Module      : uart_crc_receiver
// Description : 8N1-style serial receiver with a 4-bit CRC trailer, flagging
//               CRC mismatch and bad stop bit alongside each received byte.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_crc_receiver #(
  parameter int CLKS_PER_BIT = 1043
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] data_out,
  output logic       data_valid,
  output logic       crc_err,
  output logic       frame_err,
  output logic       busy
);

  localparam logic [12:0] c_HALF_M1 = 13'(CLKS_PER_BIT / 2 - 1);
  localparam logic [12:0] c_FULL_M1 = 13'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_CRC   = 3'd3,
    S_STOP  = 3'd4
  } state_t;

  state_t      r_state;
  state_t      w_next_state;
  logic        w_sample;
  logic        r_rst_meta;
  logic        r_rst_n_sync;
  logic        r_rx_meta;
  logic        r_rx_s;
  logic        r_rx_prev;
  logic [12:0] r_cnt;
  logic [2:0]  r_bit_idx;
  logic [7:0]  r_shift;
  logic [3:0]  r_crc;
  logic [3:0]  w_crc_exp;

  // Assert asynchronously, release two clocks after rst_n rises.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rst_meta   <= 1'b0;
      r_rst_n_sync <= 1'b0;
    end else begin
      r_rst_meta   <= 1'b1;
      r_rst_n_sync <= r_rst_meta;
    end
  end

  always_ff @(posedge clk or negedge r_rst_n_sync) begin
    if (!r_rst_n_sync) begin
      r_rx_meta <= 1'b1;
      r_rx_s    <= 1'b1;
      r_rx_prev <= 1'b1;
    end else begin
      r_rx_meta <= rx;
      r_rx_s    <= r_rx_meta;
      r_rx_prev <= r_rx_s;
    end
  end

  assign w_crc_exp = {r_shift[7] ^ r_shift[3] ^ r_shift[1] ^ r_shift[0],
                      r_shift[6] ^ r_shift[2] ^ r_shift[0],
                      r_shift[5] ^ r_shift[1],
                      r_shift[4] ^ r_shift[0]};

  assign busy = (r_state != S_IDLE);

  always_ff @(posedge clk or negedge r_rst_n_sync) begin
    if (!r_rst_n_sync) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_sample     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (r_rx_prev && !r_rx_s) begin
          w_next_state = S_START;
        end
      end
      S_START: begin
        if (r_cnt == c_HALF_M1) begin
          w_sample     = 1'b1;
          w_next_state = r_rx_s ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (r_cnt == c_FULL_M1) begin
          w_sample = 1'b1;
          if (r_bit_idx == 3'd7) begin
            w_next_state = S_CRC;
          end
        end
      end
      S_CRC: begin
        if (r_cnt == c_FULL_M1) begin
          w_sample = 1'b1;
          if (r_bit_idx == 3'd3) begin
            w_next_state = S_STOP;
          end
        end
      end
      S_STOP: begin
        if (r_cnt == c_FULL_M1) begin
          w_sample     = 1'b1;
          w_next_state = S_IDLE;
        end
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge r_rst_n_sync) begin
    if (!r_rst_n_sync) begin
      r_cnt      <= '0;
      r_bit_idx  <= '0;
      r_shift    <= '0;
      r_crc      <= '0;
      data_out   <= '0;
      data_valid <= 1'b0;
      crc_err    <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      crc_err    <= 1'b0;
      frame_err  <= 1'b0;

      if (r_state == S_IDLE || w_sample) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + 13'd1;
      end

      // Bit index restarts whenever a sample moves the FSM to a new field.
      if (r_state == S_IDLE || (w_sample && w_next_state != r_state)) begin
        r_bit_idx <= '0;
      end else if (w_sample) begin
        r_bit_idx <= r_bit_idx + 3'd1;
      end

      if (w_sample) begin
        case (r_state)
          S_DATA: r_shift <= {r_rx_s, r_shift[7:1]};
          S_CRC:  r_crc   <= {r_rx_s, r_crc[3:1]};
          S_STOP: begin
            data_out   <= r_shift;
            data_valid <= 1'b1;
            crc_err    <= (r_crc != w_crc_exp);
            frame_err  <= ~r_rx_s;
          end
          default: ;
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_crc_receiver.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_crc_receiver
// Description : Randomized self-checking bench for uart_crc_receiver.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_uart_crc_receiver;

  localparam int FAST_CPB = 37;
  localparam int SLOW_CPB = 1043;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       rx = 1'b1;
  logic       rx_slow = 1'b1;
  logic [7:0] data_out, data_out_s;
  logic       data_valid, data_valid_s;
  logic       crc_err, crc_err_s;
  logic       frame_err, frame_err_s;
  logic       busy, busy_s;

  uart_crc_receiver #(.CLKS_PER_BIT(FAST_CPB)) u_dut (
    .clk(clk), .rst_n(rst_n), .rx(rx), .data_out(data_out),
    .data_valid(data_valid), .crc_err(crc_err), .frame_err(frame_err), .busy(busy)
  );

  uart_crc_receiver #(.CLKS_PER_BIT(SLOW_CPB)) u_dut_slow (
    .clk(clk), .rst_n(rst_n), .rx(rx_slow), .data_out(data_out_s),
    .data_valid(data_valid_s), .crc_err(crc_err_s), .frame_err(frame_err_s), .busy(busy_s)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    logic       crc_err;
    logic       frame_err;
  } exp_t;

  int         n_checks = 0;
  int         n_fail = 0;
  exp_t       exp_q[$];
  exp_t       mon_e;
  logic [7:0] model_last = 8'h00;
  int         slow_valid_cnt = 0;
  logic [7:0] slow_data = 8'h00;
  logic       slow_crc = 1'b0;
  logic       slow_ferr = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Each CRC bit is the parity of the data bits named in its equation.
  function automatic logic [3:0] crc_of(input logic [7:0] d);
    return {^(d & 8'h8B), ^(d & 8'h45), ^(d & 8'h22), ^(d & 8'h11)};
  endfunction

  function automatic logic [13:0] make_frame(input logic [7:0] d, input logic [3:0] c, input logic stop);
    return {stop, c, d, 1'b0};
  endfunction

  always @(negedge clk) begin
    if (rst_n) begin
      if (data_valid) begin
        check_eq("valid_expected", 32'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          mon_e = exp_q.pop_front();
          check_eq("data_out", data_out, mon_e.data);
          check_eq("crc_err", crc_err, mon_e.crc_err);
          check_eq("frame_err", frame_err, mon_e.frame_err);
          model_last = mon_e.data;
        end
      end else if (crc_err || frame_err) begin
        check_eq("err_without_valid", {crc_err, frame_err}, 0);
      end
      if (data_valid_s) begin
        slow_valid_cnt++;
        slow_data = data_out_s;
        slow_crc  = crc_err_s;
        slow_ferr = frame_err_s;
      end
    end
  end

  task automatic send_bits(input logic which, input int cpb, input logic [13:0] bits);
    for (int i = 0; i < 14; i++) begin
      if (which) rx_slow = bits[i];
      else rx = bits[i];
      repeat (cpb) @(posedge clk);
      #1;
    end
  endtask

  task automatic send_fast(input logic [7:0] d, input logic [3:0] c, input logic stop);
    exp_t e;
    e.data      = d;
    e.crc_err   = (c != crc_of(d));
    e.frame_err = ~stop;
    exp_q.push_back(e);
    send_bits(1'b0, FAST_CPB, make_frame(d, c, stop));
    check_eq("pulse_delivered", exp_q.size(), 0);
  endtask

  task automatic idle_cycles(input int n);
    rx = 1'b1;
    if (n > 0) begin
      repeat (n) @(posedge clk);
      #1;
    end
  endtask

  initial begin
    logic [13:0] bits;
    logic [7:0]  d;
    logic [3:0]  c;
    logic        stop;
    logic        prev_stop;
    int          k;

    #2 rst_n = 1'b0;
    #1;
    check_eq("rst_data_out", data_out, 8'h00);
    check_eq("rst_flags", {data_valid, crc_err, frame_err, busy}, 0);
    check_eq("rst_busy_slow", busy_s, 0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check_eq("post_rst_busy", busy, 0);

    // Nominal-rate frame, then a 200-cycle false start on the same line.
    send_bits(1'b1, SLOW_CPB, make_frame(8'hA5, 4'b0011, 1'b1));
    check_eq("slow_cnt", slow_valid_cnt, 1);
    check_eq("slow_data", slow_data, 8'hA5);
    check_eq("slow_errs", {slow_crc, slow_ferr}, 0);
    rx_slow = 1'b0;
    repeat (200) @(posedge clk);
    #1 rx_slow = 1'b1;
    repeat (SLOW_CPB) @(posedge clk);
    #1;
    check_eq("slow_glitch_busy", busy_s, 0);
    check_eq("slow_glitch_cnt", slow_valid_cnt, 1);
    check_eq("slow_glitch_data", data_out_s, 8'hA5);

    idle_cycles(5);
    send_fast(8'hA5, 4'b0011, 1'b1);
    send_fast(8'hA5, 4'b1011, 1'b1);
    send_fast(8'hFF, 4'b0100, 1'b1);
    send_fast(8'h00, 4'b0000, 1'b1);

    // Bad stop bit, then the line stays low for three frame times.
    idle_cycles(5);
    send_fast(8'h3C, crc_of(8'h3C), 1'b0);
    repeat (3 * 14 * FAST_CPB) @(posedge clk);
    #1;
    check_eq("held_low_busy", busy, 0);
    idle_cycles(FAST_CPB);
    send_fast(8'hC3, crc_of(8'hC3), 1'b1);

    // Reset pulse in the middle of data bit 4.
    idle_cycles(5);
    bits = make_frame(8'h5A, crc_of(8'h5A), 1'b1);
    for (int i = 0; i < 5; i++) begin
      rx = bits[i];
      repeat (FAST_CPB) @(posedge clk);
      #1;
    end
    rx = bits[5];
    repeat (FAST_CPB / 2) @(posedge clk);
    #1;
    check_eq("midframe_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    check_eq("midrst_data_out", data_out, 8'h00);
    check_eq("midrst_flags", {data_valid, crc_err, frame_err, busy}, 0);
    rx = 1'b1;
    repeat (5) @(posedge clk);
    #1 rst_n = 1'b1;
    model_last = 8'h00;
    repeat (2 * FAST_CPB) @(posedge clk);
    #1;
    check_eq("post_abort_busy", busy, 0);
    check_eq("post_abort_data", data_out, model_last);
    send_fast(8'h5A, crc_of(8'h5A), 1'b1);

    prev_stop = 1'b1;
    for (int n = 0; n < 30; n++) begin
      d    = 8'($urandom);
      c    = ($urandom_range(0, 1) == 0) ? crc_of(d) : 4'($urandom);
      stop = ($urandom_range(0, 7) != 0);
      if (!prev_stop) idle_cycles(int'($urandom_range(3, FAST_CPB)));
      else idle_cycles(int'($urandom_range(0, 3)));
      if ($urandom_range(0, 3) == 0) begin
        idle_cycles(4);
        k = int'($urandom_range(1, FAST_CPB / 2 - 3));
        rx = 1'b0;
        repeat (k) @(posedge clk);
        #1;
        idle_cycles(FAST_CPB);
        check_eq("glitch_busy", busy, 0);
        check_eq("glitch_data_hold", data_out, model_last);
      end
      send_fast(d, c, stop);
      prev_stop = stop;
    end

    idle_cycles(2 * FAST_CPB);
    check_eq("queue_drained", exp_q.size(), 0);
    check_eq("final_busy", busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
